// File: rtl/vna_trig_responder.sv
// vna_trig_responder
//   Responder end of the VNA_TRIG / VNA_RDY handshake. It accepts trigger
//   pulses that stay high long enough, then drops VNA_RDY for a fixed
//   acquisition time. It records which RF switch port was selected at each
//   accepted trigger, and it flags protocol violations in sticky error bits.
//
// Ports
//   Clk        in   system clock, rising edge
//   Rst        in   asynchronous active-high reset
//   VNA_TRIG   in   trigger from sequencer (asynchronous, synchronised here)
//   sw_J1..3   in   switch port 0..2 select, active-low
//   clr_err    in   synchronous clear of trig_err / sw_err (set wins)
//   VNA_RDY    out  1 = ready for trigger, 0 = acquiring
//   busy       out  1 while acquiring
//   point_cnt  out  accepted-trigger count (wraps)
//   last_port  out  port code latched at last accepted trigger, 3 = invalid
//   trig_err   out  sticky: trigger rising edge while acquiring
//   sw_err     out  sticky: invalid port at accept or port change while acquiring
module vna_trig_responder #(
    parameter int unsigned ACQ_CYCLES    = 100,
    parameter int unsigned MIN_TRIG_HIGH = 3,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             VNA_TRIG,
    input  logic             sw_J1,
    input  logic             sw_J2,
    input  logic             sw_J3,
    input  logic             clr_err,
    output logic             VNA_RDY,
    output logic             busy,
    output logic [CNT_W-1:0] point_cnt,
    output logic [1:0]       last_port,
    output logic             trig_err,
    output logic             sw_err
);

    // Counters only ever hold 0..N-1, so $clog2(N) bits are enough.
    localparam int unsigned QW = (MIN_TRIG_HIGH > 1) ? $clog2(MIN_TRIG_HIGH) : 1;
    localparam int unsigned AW = (ACQ_CYCLES > 1) ? $clog2(ACQ_CYCLES) : 1;
    localparam logic [QW-1:0] QUAL_LAST = QW'(MIN_TRIG_HIGH - 1);
    localparam logic [AW-1:0] ACQ_LAST  = AW'(ACQ_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_QUALIFY,
        S_ACQUIRE,
        S_WAIT_LOW
    } state_t;

    state_t           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic [QW-1:0]    qual_cnt_q, qual_cnt_d;
    logic [AW-1:0]    acq_cnt_q, acq_cnt_d;
    logic [CNT_W-1:0] point_cnt_q, point_cnt_d;
    logic [1:0]       last_port_q, last_port_d;
    logic             trig_err_q, trig_err_d;
    logic             sw_err_q, sw_err_d;

    logic             trig_rise;
    logic [1:0]       port_code;
    logic             accept;
    logic             trig_set;
    logic             sw_set;

    assign trig_rise = s2_q & ~s3_q;

    // Exactly one active-low select gives its port number; anything else is 3.
    always_comb begin
        case ({sw_J3, sw_J2, sw_J1})
            3'b110:  port_code = 2'd0;
            3'b101:  port_code = 2'd1;
            3'b011:  port_code = 2'd2;
            default: port_code = 2'd3;
        endcase
    end

    // State register plus synchroniser and datapath registers.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= S_IDLE;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            qual_cnt_q  <= '0;
            acq_cnt_q   <= '0;
            point_cnt_q <= '0;
            last_port_q <= 2'd3;
            trig_err_q  <= 1'b0;
            sw_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_q        <= VNA_TRIG;
            s2_q        <= s1_q;
            s3_q        <= s2_q;
            qual_cnt_q  <= qual_cnt_d;
            acq_cnt_q   <= acq_cnt_d;
            point_cnt_q <= point_cnt_d;
            last_port_q <= last_port_d;
            trig_err_q  <= trig_err_d;
            sw_err_q    <= sw_err_d;
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        state_d     = state_q;
        qual_cnt_d  = qual_cnt_q;
        acq_cnt_d   = acq_cnt_q;
        point_cnt_d = point_cnt_q;
        last_port_d = last_port_q;
        accept      = 1'b0;
        trig_set    = 1'b0;
        sw_set      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (s2_q) begin
                    if (MIN_TRIG_HIGH == 1) begin
                        accept = 1'b1;
                    end else begin
                        qual_cnt_d = QW'(1);
                        state_d    = S_QUALIFY;
                    end
                end
            end
            S_QUALIFY: begin
                if (!s2_q) begin
                    state_d = S_IDLE;
                end else if (qual_cnt_q == QUAL_LAST) begin
                    accept = 1'b1;
                end else begin
                    qual_cnt_d = qual_cnt_q + 1'b1;
                end
            end
            S_ACQUIRE: begin
                if (port_code != last_port_q) begin
                    sw_set = 1'b1;
                end
                if (acq_cnt_q == ACQ_LAST) begin
                    // A trigger rising on the final cycle is absorbed by
                    // WAIT_LOW rather than reported as an error.
                    state_d = s2_q ? S_WAIT_LOW : S_IDLE;
                end else begin
                    acq_cnt_d = acq_cnt_q + 1'b1;
                    if (trig_rise) begin
                        trig_set = 1'b1;
                    end
                end
            end
            S_WAIT_LOW: begin
                if (!s2_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            state_d     = S_ACQUIRE;
            acq_cnt_d   = '0;
            point_cnt_d = point_cnt_q + 1'b1;
            last_port_d = port_code;
            if (port_code == 2'd3) begin
                sw_set = 1'b1;
            end
        end

        trig_err_d = trig_set | (trig_err_q & ~clr_err);
        sw_err_d   = sw_set   | (sw_err_q   & ~clr_err);
    end

    // Outputs: all derived from registers, so they change only on edges.
    always_comb begin
        VNA_RDY   = (state_q != S_ACQUIRE);
        busy      = (state_q == S_ACQUIRE);
        point_cnt = point_cnt_q;
        last_port = last_port_q;
        trig_err  = trig_err_q;
        sw_err    = sw_err_q;
    end

endmodule

// File: tb/tb_vna_trig_responder.sv
`timescale 1ns/1ps
module tb_vna_trig_responder;

    localparam int unsigned ACQ  = 100;
    localparam int unsigned MINH = 3;
    localparam int unsigned CW   = 8;
    localparam logic [13:0] RST_VEC = {1'b1, 1'b0, 8'h00, 2'b11, 1'b0, 1'b0};

    logic          Clk = 1'b0;
    logic          Rst, VNA_TRIG, sw_J1, sw_J2, sw_J3, clr_err;
    logic          VNA_RDY, busy, trig_err, sw_err;
    logic [CW-1:0] point_cnt;
    logic [1:0]    last_port;
    logic [13:0]   dut_vec;

    int n_cmp  = 0;
    int n_fail = 0;

    vna_trig_responder #(
        .ACQ_CYCLES   (ACQ),
        .MIN_TRIG_HIGH(MINH),
        .CNT_W        (CW)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .VNA_TRIG (VNA_TRIG),
        .sw_J1    (sw_J1),
        .sw_J2    (sw_J2),
        .sw_J3    (sw_J3),
        .clr_err  (clr_err),
        .VNA_RDY  (VNA_RDY),
        .busy     (busy),
        .point_cnt(point_cnt),
        .last_port(last_port),
        .trig_err (trig_err),
        .sw_err   (sw_err)
    );

    always #5 Clk = ~Clk;

    assign dut_vec = {VNA_RDY, busy, point_cnt, last_port, trig_err, sw_err};

    // Reference model: tracks remaining acquisition time, the length of the
    // current run of high trigger samples, and whether a release is pending.
    int            m_acq_left;
    int            m_run;
    bit            m_need_low;
    bit            m_terr;
    bit            m_serr;
    logic [CW-1:0] m_cnt;
    logic [1:0]    m_last;
    logic [2:0]    m_hist;   // trigger samples from 1, 2, 3 edges ago

    function automatic logic [1:0] decode(logic j1, logic j2, logic j3);
        int lows;
        lows = int'(!j1) + int'(!j2) + int'(!j3);
        if (lows != 1) return 2'd3;
        if (!j1) return 2'd0;
        if (!j2) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [13:0] exp_vec();
        return {m_acq_left == 0, m_acq_left > 0, m_cnt, m_last, m_terr, m_serr};
    endfunction

    always @(posedge Clk or posedge Rst) begin : ref_model
        int            left, run;
        bit            need_low, tset, sset, x, xprev;
        logic [CW-1:0] cnt;
        logic [1:0]    last, code;
        if (Rst) begin
            m_acq_left <= 0;
            m_run      <= 0;
            m_need_low <= 1'b0;
            m_terr     <= 1'b0;
            m_serr     <= 1'b0;
            m_cnt      <= '0;
            m_last     <= 2'd3;
            m_hist     <= '0;
        end else begin
            left     = m_acq_left;
            run      = m_run;
            need_low = m_need_low;
            cnt      = m_cnt;
            last     = m_last;
            x        = m_hist[1];
            xprev    = m_hist[2];
            code     = decode(sw_J1, sw_J2, sw_J3);
            tset     = 1'b0;
            sset     = 1'b0;
            if (left > 0) begin
                if (code != last) sset = 1'b1;
                if (x && !xprev && left > 1) tset = 1'b1;
                left = left - 1;
                if (left == 0) need_low = x;
            end else if (need_low) begin
                if (!x) need_low = 1'b0;
            end else begin
                run = x ? run + 1 : 0;
                if (run == int'(MINH)) begin
                    run  = 0;
                    left = ACQ;
                    cnt  = cnt + 1'b1;
                    last = code;
                    if (code == 2'd3) sset = 1'b1;
                end
            end
            m_acq_left <= left;
            m_run      <= run;
            m_need_low <= need_low;
            m_cnt      <= cnt;
            m_last     <= last;
            m_terr     <= tset | (m_terr & !clr_err);
            m_serr     <= sset | (m_serr & !clr_err);
            m_hist     <= {m_hist[1:0], VNA_TRIG};
        end
    end

    task automatic cycle();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic test_reset();
        Rst = 1'b1; VNA_TRIG = 1'b0; clr_err = 1'b0;
        {sw_J3, sw_J2, sw_J1} = 3'b110;
        repeat (3) cycle();
        n_cmp++;
        if (dut_vec !== RST_VEC) begin
            n_fail++; $display("FAIL reset_hold got=%h exp=%h", dut_vec, RST_VEC);
        end
        Rst = 1'b0;
        for (int k = 0; k < 50; k++) begin
            cycle();
            n_cmp++;
            if (dut_vec !== RST_VEC || dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", k, dut_vec, RST_VEC);
            end
        end
    endtask

    task automatic test_pulse();
        int fall = -1, low = 0;
        {sw_J3, sw_J2, sw_J1} = 3'b110;
        VNA_TRIG = 1'b1;
        for (int k = 0; k < 140; k++) begin
            cycle();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL pulse_model cyc=%0d got=%h exp=%h", k, dut_vec, exp_vec());
            end
            if (!VNA_RDY) begin
                if (fall < 0) fall = k;
                low++;
            end
            if (k == 24) VNA_TRIG = 1'b0;
        end
        n_cmp++;
        if (fall !== 4) begin
            n_fail++; $display("FAIL pulse_latency got=%0d exp=4", fall);
        end
        n_cmp++;
        if (low !== int'(ACQ)) begin
            n_fail++; $display("FAIL pulse_low_len got=%0d exp=%0d", low, ACQ);
        end
        n_cmp++;
        if ({point_cnt, last_port, trig_err, sw_err} !== {8'd1, 2'd0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL pulse_result got cnt=%0d port=%0d te=%b se=%b exp cnt=1 port=0 te=0 se=0",
                               point_cnt, last_port, trig_err, sw_err);
        end
    endtask

    task automatic test_glitch();
        int low = 0;
        logic [CW-1:0] c0 = m_cnt;
        VNA_TRIG = 1'b1;
        for (int k = 0; k < 24; k++) begin
            cycle();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL glitch_model cyc=%0d got=%h exp=%h", k, dut_vec, exp_vec());
            end
            if (!VNA_RDY) low++;
            if (k == 1) VNA_TRIG = 1'b0;
        end
        n_cmp++;
        if (low !== 0 || point_cnt !== c0) begin
            n_fail++; $display("FAIL glitch_reject got low=%0d cnt=%0d exp low=0 cnt=%0d", low, point_cnt, c0);
        end
    endtask

    task automatic test_overlap();
        int falls = 0;
        bit prev = 1'b1;
        logic [CW-1:0] c0 = m_cnt;
        VNA_TRIG = 1'b1;
        for (int k = 0; k < 130; k++) begin
            cycle();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL overlap_model cyc=%0d got=%h exp=%h", k, dut_vec, exp_vec());
            end
            if (prev && !VNA_RDY) falls++;
            prev = VNA_RDY;
            if (k == 4)  VNA_TRIG = 1'b0;
            if (k == 34) VNA_TRIG = 1'b1;
            if (k == 44) VNA_TRIG = 1'b0;
        end
        n_cmp++;
        if (falls !== 1 || trig_err !== 1'b1 || point_cnt !== c0 + 8'd1) begin
            n_fail++; $display("FAIL overlap_err got acq=%0d te=%b cnt=%0d exp acq=1 te=1 cnt=%0d",
                               falls, trig_err, point_cnt, c0 + 8'd1);
        end
        clr_err = 1'b1;
        cycle();
        clr_err = 1'b0;
        n_cmp++;
        if (trig_err !== 1'b0 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL overlap_clr got te=%b exp te=0", trig_err);
        end
    endtask

    task automatic test_sw_err();
        logic [CW-1:0] c0 = m_cnt;
        for (int run = 0; run < 2; run++) begin
            {sw_J3, sw_J2, sw_J1} = (run == 0) ? 3'b100 : 3'b101;
            VNA_TRIG = 1'b1;
            for (int k = 0; k < 115; k++) begin
                cycle();
                n_cmp++;
                if (dut_vec !== exp_vec()) begin
                    n_fail++; $display("FAIL swerr_model run=%0d cyc=%0d got=%h exp=%h", run, k, dut_vec, exp_vec());
                end
                if (k == 4) VNA_TRIG = 1'b0;
                if (run == 1 && k == 40) {sw_J3, sw_J2, sw_J1} = 3'b011;
            end
            n_cmp++;
            if (sw_err !== 1'b1 || last_port !== ((run == 0) ? 2'd3 : 2'd1)) begin
                n_fail++; $display("FAIL swerr_flag run=%0d got se=%b port=%0d exp se=1 port=%0d",
                                   run, sw_err, last_port, (run == 0) ? 3 : 1);
            end
            clr_err = 1'b1;
            cycle();
            clr_err = 1'b0;
            n_cmp++;
            if (sw_err !== 1'b0) begin
                n_fail++; $display("FAIL swerr_clr run=%0d got se=%b exp se=0", run, sw_err);
            end
        end
        {sw_J3, sw_J2, sw_J1} = 3'b110;
        n_cmp++;
        if (point_cnt !== c0 + 8'd2) begin
            n_fail++; $display("FAIL swerr_cnt got=%0d exp=%0d", point_cnt, c0 + 8'd2);
        end
    endtask

    // Trigger rises either on the last acquisition cycle (absorbed, no error)
    // or one cycle earlier (error).
    task automatic test_boundary();
        for (int v = 0; v < 2; v++) begin
            int falls = 0, low = 0;
            bit prev = 1'b1;
            logic [CW-1:0] c0 = m_cnt;
            VNA_TRIG = 1'b1;
            for (int k = 0; k < 160; k++) begin
                cycle();
                n_cmp++;
                if (dut_vec !== exp_vec()) begin
                    n_fail++; $display("FAIL boundary_model v=%0d cyc=%0d got=%h exp=%h", v, k, dut_vec, exp_vec());
                end
                if (prev && !VNA_RDY) falls++;
                if (!VNA_RDY) low++;
                prev = VNA_RDY;
                if (k == 3) VNA_TRIG = 1'b0;
                if (k == ((v == 0) ? 101 : 100)) VNA_TRIG = 1'b1;
                if (k == 130) VNA_TRIG = 1'b0;
            end
            n_cmp++;
            if (falls !== 1 || low !== int'(ACQ) || point_cnt !== c0 + 8'd1 || trig_err !== (v == 1)) begin
                n_fail++; $display("FAIL boundary v=%0d got acq=%0d low=%0d cnt=%0d te=%b exp acq=1 low=%0d cnt=%0d te=%0d",
                                   v, falls, low, point_cnt, trig_err, ACQ, c0 + 8'd1, v);
            end
            clr_err = 1'b1;
            cycle();
            clr_err = 1'b0;
        end
    endtask

    task automatic test_random();
        int hold = 0;
        for (int k = 0; k < 4000; k++) begin
            if (hold == 0) begin
                VNA_TRIG = ~VNA_TRIG;
                hold = VNA_TRIG ? $urandom_range(1, 12) : $urandom_range(1, 60);
            end
            hold--;
            if ($urandom_range(0, 49) == 0) begin
                case ($urandom_range(0, 4))
                    0:       {sw_J3, sw_J2, sw_J1} = 3'b110;
                    1:       {sw_J3, sw_J2, sw_J1} = 3'b101;
                    2:       {sw_J3, sw_J2, sw_J1} = 3'b011;
                    default: {sw_J3, sw_J2, sw_J1} = 3'($urandom);
                endcase
            end
            clr_err = ($urandom_range(0, 31) == 0);
            cycle();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL random_model cyc=%0d got=%h exp=%h", k, dut_vec, exp_vec());
            end
        end
        VNA_TRIG = 1'b0; clr_err = 1'b0;
        {sw_J3, sw_J2, sw_J1} = 3'b110;
        repeat (150) cycle();
        n_cmp++;
        if (VNA_RDY !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL random_settle got rdy=%b busy=%b exp rdy=1 busy=0", VNA_RDY, busy);
        end
    endtask

    task automatic test_async_reset();
        int k = 0;
        VNA_TRIG = 1'b1;
        while (VNA_RDY && k < 20) begin
            cycle();
            k++;
            if (k == 4) VNA_TRIG = 1'b0;
        end
        VNA_TRIG = 1'b0;
        n_cmp++;
        if (VNA_RDY !== 1'b0) begin
            n_fail++; $display("FAIL areset_start got rdy=%b exp rdy=0", VNA_RDY);
        end
        for (int j = 0; j < 50; j++) begin
            cycle();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL areset_model cyc=%0d got=%h exp=%h", j, dut_vec, exp_vec());
            end
        end
        #2 Rst = 1'b1;
        #1;
        n_cmp++;
        if (dut_vec !== RST_VEC) begin
            n_fail++; $display("FAIL areset_now got=%h exp=%h", dut_vec, RST_VEC);
        end
        @(negedge Clk);
        Rst = 1'b0;
        cycle();
        n_cmp++;
        if (dut_vec !== RST_VEC || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL areset_after got=%h exp=%h", dut_vec, RST_VEC);
        end
    endtask

    task automatic test_wrap();
        int tmo;
        for (int i = 1; i <= 256; i++) begin
            VNA_TRIG = 1'b1;
            repeat (4) cycle();
            VNA_TRIG = 1'b0;
            tmo = 0;
            while (VNA_RDY && tmo < 10) begin cycle(); tmo++; end
            while (!VNA_RDY && tmo < 200) begin
                cycle();
                tmo++;
                n_cmp++;
                if (dut_vec !== exp_vec()) begin
                    n_fail++; $display("FAIL wrap_model trig=%0d got=%h exp=%h", i, dut_vec, exp_vec());
                end
            end
            if (tmo >= 200 || tmo < 10 && VNA_RDY && busy) begin
                n_fail++; $display("FAIL wrap_timeout trig=%0d got rdy=%b exp rdy=1", i, VNA_RDY);
                break;
            end
            cycle();
            if (i == 255) begin
                n_cmp++;
                if (point_cnt !== 8'd255) begin
                    n_fail++; $display("FAIL wrap_255 got=%0d exp=255", point_cnt);
                end
            end
            if (i == 256) begin
                n_cmp++;
                if (point_cnt !== 8'd0) begin
                    n_fail++; $display("FAIL wrap_256 got=%0d exp=0", point_cnt);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_pulse();
        test_glitch();
        test_overlap();
        test_sw_err();
        test_boundary();
        test_random();
        test_async_reset();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vna_trig_responder.md
Name: vna_trig_responder

Overview:
- Behavioural-synthesisable VNA emulator: the responder end of the VNA_TRIG / VNA_RDY handshake driven by the switch sequencer.
- Accepts qualified trigger pulses and drops VNA_RDY for a programmable acquisition time.
- Records which RF switch port (sw_J1..sw_J3, active-low) was selected at each trigger, and flags protocol violations.
- Used for FPGA loopback self-test and as the bench-side model.

Parameters:
- ACQ_CYCLES, 100, number of Clk cycles VNA_RDY is held low per accepted trigger (≥1).
- MIN_TRIG_HIGH, 3, consecutive synchronised-high samples required to accept a trigger (≥1).
- CNT_W, 8, width of point_cnt.

Ports:
- Clk  in  1  system clock, all logic on rising edge.
- Rst  in  1  asynchronous, active-high reset.
- VNA_TRIG  in  1  trigger from sequencer, treated as asynchronous.
- sw_J1  in  1  switch port 0 select, active-low.
- sw_J2  in  1  switch port 1 select, active-low.
- sw_J3  in  1  switch port 2 select, active-low.
- clr_err  in  1  synchronous clear of sticky error flags.
- VNA_RDY  out  1  high = ready for trigger; low = acquiring.
- busy  out  1  high while in ACQUIRE.
- point_cnt  out  CNT_W  accepted-trigger count.
- last_port  out  2  port code captured at last accepted trigger; 3 = invalid.
- trig_err  out  1  sticky: trigger rising edge seen while not ready.
- sw_err  out  1  sticky: invalid switch pattern at accept, or pattern change during ACQUIRE.

Behaviour:
- Reset (async, any time, including mid-acquisition):
  - state IDLE, VNA_RDY=1, busy=0, point_cnt=0, last_port=3, trig_err=0, sw_err=0.
  - Sync flops and internal counters = 0.
- Synchroniser: VNA_TRIG passes a 2-flop synchroniser (s2). The FSM uses only s2 and its 1-cycle delayed copy s3. Rising edge = s2 & ~s3.
- Port decode (combinational on sw_J*):
  - Exactly one line low gives code 0/1/2 for J1/J2/J3.
  - None low or more than one low gives code 3.
- FSM states:
  - IDLE: VNA_RDY=1. When s2=1, set qual_cnt=1 and go to QUALIFY. If MIN_TRIG_HIGH=1, accept directly instead.
  - QUALIFY: VNA_RDY=1.
    - s2=0 → IDLE, no side effects (glitch rejected).
    - s2=1 with qual_cnt+1 = MIN_TRIG_HIGH → accept.
    - Otherwise increment qual_cnt.
  - Accept (registered on the same edge):
    - go to ACQUIRE; VNA_RDY←0, busy←1.
    - point_cnt←point_cnt+1, wrapping to 0 at 2^CNT_W−1.
    - last_port←decoded code; if code is 3, set sw_err.
    - acq_cnt←0.
  - ACQUIRE: VNA_RDY=0.
    - acq_cnt increments each cycle.
    - When acq_cnt = ACQ_CYCLES−1: VNA_RDY←1, busy←0; next state WAIT_LOW if s2=1, else IDLE.
    - VNA_RDY is therefore low for exactly ACQ_CYCLES cycles.
  - WAIT_LOW: VNA_RDY=1. Stay until s2=0, then IDLE. A held trigger never produces a second acquisition.
- Latency: with VNA_TRIG stable high from before edge e0, VNA_RDY is registered low at edge e0+MIN_TRIG_HIGH+1 (2 sync + qualification).
- Errors:
  - A rising edge of s2 while in ACQUIRE sets trig_err; the trigger is ignored.
  - In ACQUIRE, a decoded code differing from last_port sets sw_err.
  - clr_err clears both flags. If a set condition and clr_err occur in the same cycle, set wins.
- Boundaries:
  - Trigger falling during QUALIFY at count MIN_TRIG_HIGH−1 → rejected.
  - Trigger rising on the same cycle ACQUIRE ends → treated as WAIT_LOW, not accepted, no trig_err.

Test Plan:
- Reset release, VNA_TRIG=0, sw_J*=3'b110 → VNA_RDY=1, last_port=3, point_cnt=0, no errors for 50 cycles.
- 25-cycle VNA_TRIG pulse, sw_J1=0, J2=J3=1 → VNA_RDY falls at e0+4 (defaults), stays low exactly 100 cycles; point_cnt=1, last_port=0, no errors.
- 2-cycle VNA_TRIG glitch → VNA_RDY never falls, point_cnt unchanged.
- Second pulse 30 cycles into acquisition → trig_err=1, only one acquisition, point_cnt+1. Then clr_err pulse → trig_err=0.
- Trigger with J1 and J2 both low → last_port=3, sw_err=1. Separate run: switch J2→J3 mid-ACQUIRE → sw_err=1.
- Rst asserted at acq_cnt=50 → VNA_RDY=1 and all outputs at reset values immediately; 256 accepted triggers wrap point_cnt to 0.
